// File: rtl/psum_accumulator_pkg.sv
// Shared widths, FSM encoding and saturation bounds for the partial-sum accumulator.
// Optional build macro PSUM_SAT_EN selects saturating adds (see psum_sat_adder).
package psum_accumulator_pkg;

  localparam int unsigned PROD_WIDTH = 24;
  localparam int unsigned ACC_WIDTH  = 32;
  localparam int unsigned LEN_WIDTH  = 4;

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_OUT   = 2'd2
  } state_e;

  typedef struct packed {
    logic busy;
    logic prod_ready;
    logic psum_valid;
  } flags_t;

  // Handshake outputs implied by a state; registered alongside the state itself.
  function automatic flags_t flags_of(state_e s);
    flags_t f;
    f.busy       = (s != S_IDLE);
    f.prod_ready = (s == S_ACCUM);
    f.psum_valid = (s == S_OUT);
    return f;
  endfunction

endpackage

// File: rtl/psum_accumulator_if.sv
// Window control, product stream and psum stream of the accumulator.
interface psum_accumulator_if;
  import psum_accumulator_pkg::*;

  logic                         start;
  logic [LEN_WIDTH-1:0]         filt_len;
  logic signed [ACC_WIDTH-1:0]  psum_in;
  logic                         prod_valid;
  logic signed [PROD_WIDTH-1:0] prod;
  logic                         prod_ready;
  logic                         psum_valid;
  logic signed [ACC_WIDTH-1:0]  psum_out;
  logic                         psum_ready;
  logic                         busy;
  logic                         ovf;

  modport master (
    output start, filt_len, psum_in, prod_valid, prod, psum_ready,
    input  prod_ready, psum_valid, psum_out, busy, ovf
  );

  modport slave (
    input  start, filt_len, psum_in, prod_valid, prod, psum_ready,
    output prod_ready, psum_valid, psum_out, busy, ovf
  );

endinterface

// File: rtl/psum_accumulator_sat_adder.sv
// Signed ACC_WIDTH adder; clamps to ACC_MAX/ACC_MIN when PSUM_SAT_EN is defined, else wraps.
module psum_sat_adder
  import psum_accumulator_pkg::*;
(
  input  logic signed [ACC_WIDTH-1:0] a,
  input  logic signed [ACC_WIDTH-1:0] b,
  output logic signed [ACC_WIDTH-1:0] sum,
  output logic                        ovf
);

  logic signed [ACC_WIDTH-1:0] raw;
  assign raw = a + b;

`ifdef PSUM_SAT_EN
  // Overflow only when both operands share a sign the result does not.
  logic wrapped;
  assign wrapped = (a[ACC_WIDTH-1] == b[ACC_WIDTH-1]) && (raw[ACC_WIDTH-1] != a[ACC_WIDTH-1]);
  assign sum     = wrapped ? (a[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX) : raw;
  assign ovf     = wrapped;
`else
  assign sum = raw;
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/psum_accumulator.sv
// Sums one filter window of signed products onto a seed psum and hands it downstream.
// Build macro PSUM_SAT_EN enables saturating accumulation and the sticky ovf flag.
module psum_accumulator
  import psum_accumulator_pkg::*;
(
  input logic               clk,
  input logic               rst,
  psum_accumulator_if.slave io
);

  state_e                      state;
  flags_t                      flags;
  logic signed [ACC_WIDTH-1:0] acc;
  logic [LEN_WIDTH-1:0]        cnt;

  logic                        beat;
  logic                        load;
  state_e                      load_state;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] sum;
  logic                        add_ovf;

  // A new window is taken in IDLE, or in OUT on the same cycle the result drains.
  assign beat       = io.prod_valid && flags.prod_ready;
  assign load       = io.start && ((state == S_IDLE) || ((state == S_OUT) && io.psum_ready));
  assign load_state = (io.filt_len == '0) ? S_OUT : S_ACCUM;
  assign prod_ext   = ACC_WIDTH'(io.prod);

  psum_sat_adder u_adder (
    .a   (acc),
    .b   (prod_ext),
    .sum (sum),
    .ovf (add_ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      flags <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (load) begin
      acc   <= io.psum_in;
      cnt   <= io.filt_len;
      state <= load_state;
      flags <= flags_of(load_state);
    end else begin
      case (state)
        S_IDLE: ;
        S_ACCUM: begin
          if (beat) begin
            acc <= sum;
            cnt <= cnt - LEN_WIDTH'(1);
            if (cnt == LEN_WIDTH'(1)) begin
              state <= S_OUT;
              flags <= flags_of(S_OUT);
            end
          end
        end
        S_OUT: begin
          if (io.psum_ready) begin
            state <= S_IDLE;
            flags <= flags_of(S_IDLE);
          end
        end
        default: begin
          state <= S_IDLE;
          flags <= flags_of(S_IDLE);
        end
      endcase
    end
  end

`ifdef PSUM_SAT_EN
  logic ovf_q;

  // Sticky for the whole window; cleared when the next window is seeded.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else if (load) begin
      ovf_q <= 1'b0;
    end else if (beat) begin
      ovf_q <= ovf_q | add_ovf;
    end
  end

  assign io.ovf = ovf_q;
`else
  assign io.ovf = add_ovf;
`endif

  assign io.busy       = flags.busy;
  assign io.prod_ready = flags.prod_ready;
  assign io.psum_valid = flags.psum_valid;
  assign io.psum_out   = acc;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator with a transaction-level model checked every cycle.
module tb_psum_accumulator;
  import psum_accumulator_pkg::*;

  logic clk = 1'b0;
  logic rst;

  psum_accumulator_if bus ();

  psum_accumulator dut (
    .clk (clk),
    .rst (rst),
    .io  (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -MAXV - 64'sd1;

  // Model: a window is in flight while m_busy; m_left products still owed.
  bit     m_busy;
  int     m_left;
  longint m_sum;
  bit     m_ovf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, $signed(act), $signed(exp), $time);
    end
  endtask

  function automatic longint add_model(input longint a, input longint b, output bit o);
    longint s;
    s = a + b;
    o = 1'b0;
`ifdef PSUM_SAT_EN
    if (s > MAXV) begin
      s = MAXV;
      o = 1'b1;
    end else if (s < MINV) begin
      s = MINV;
      o = 1'b1;
    end
`else
    s = longint'(int'(s));
`endif
    return s;
  endfunction

  always @(posedge clk) begin
    bit o;
    if (!rst) begin
      m_busy = 1'b0;
      m_left = 0;
      m_sum  = 0;
      m_ovf  = 1'b0;
    end else if (bus.start && (!m_busy || (m_left == 0 && bus.psum_ready))) begin
      m_busy = 1'b1;
      m_left = int'(bus.filt_len);
      m_sum  = longint'(bus.psum_in);
      m_ovf  = 1'b0;
    end else if (m_busy && m_left > 0 && bus.prod_valid) begin
      m_sum  = add_model(m_sum, longint'(bus.prod), o);
      m_ovf  = m_ovf | o;
      m_left = m_left - 1;
    end else if (m_busy && m_left == 0 && bus.psum_ready) begin
      m_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("busy",       64'(bus.busy),       64'(m_busy));
      chk("prod_ready", 64'(bus.prod_ready), 64'(m_busy && m_left > 0));
      chk("psum_valid", 64'(bus.psum_valid), 64'(m_busy && m_left == 0));
      chk("ovf",        64'(bus.ovf),        64'(m_ovf));
      if (m_busy && m_left == 0)
        chk("psum_out", 64'(bus.psum_out), 64'(m_sum));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_win(input int len, input longint seed);
    bus.start    = 1'b1;
    bus.filt_len = LEN_WIDTH'(len);
    bus.psum_in  = ACC_WIDTH'(seed);
    tick();
    bus.start    = 1'b0;
  endtask

  task automatic beat(input longint p);
    bus.prod_valid = 1'b1;
    bus.prod       = PROD_WIDTH'(p);
    tick();
    bus.prod_valid = 1'b0;
  endtask

  task automatic drain();
    bus.psum_ready = 1'b1;
    tick();
    bus.psum_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b0;
    bus.start      = 1'b0;
    bus.filt_len   = '0;
    bus.psum_in    = '0;
    bus.prod_valid = 1'b0;
    bus.prod       = '0;
    bus.psum_ready = 1'b0;
    tick();
    check_en = 1'b1;
    tick();
    rst = 1'b1;
    tick();

    // Reset in the middle of a window
    start_win(5, 3);
    beat(1);
    beat(2);
    rst = 1'b0;
    tick();
    tick();
    chk("rst_busy",       64'(bus.busy),       64'(0));
    chk("rst_prod_ready", 64'(bus.prod_ready), 64'(0));
    chk("rst_psum_valid", 64'(bus.psum_valid), 64'(0));
    chk("rst_ovf",        64'(bus.ovf),        64'(0));
    rst = 1'b1;
    tick();

    // Basic back-to-back window
    start_win(3, 10);
    beat(5);
    beat(-7);
    beat(100);
    chk("basic_valid", 64'(bus.psum_valid), 64'(1));
    chk("basic_sum",   64'(bus.psum_out),   64'(108));
    drain();
    chk("basic_idle",  64'(bus.busy),       64'(0));

    // Gaps between beats, then backpressure on the result
    start_win(3, 10);
    beat(5);
    tick();
    beat(-7);
    tick();
    tick();
    chk("stall_no_valid", 64'(bus.psum_valid), 64'(0));
    beat(100);
    for (int i = 0; i < 4; i++) begin
      chk("bp_sum",   64'(bus.psum_out),   64'(108));
      chk("bp_valid", 64'(bus.psum_valid), 64'(1));
      tick();
    end
    drain();
    chk("bp_idle",       64'(bus.busy),       64'(0));
    chk("bp_valid_drop", 64'(bus.psum_valid), 64'(0));

    // Zero-length window
    start_win(0, -42);
    chk("zero_valid", 64'(bus.psum_valid), 64'(1));
    chk("zero_sum",   64'(bus.psum_out),   64'(-42));
    chk("zero_ready", 64'(bus.prod_ready), 64'(0));
    drain();

    // Positive overflow, single beat
    start_win(1, 2147483600);
    beat(100);
`ifdef PSUM_SAT_EN
    chk("ovf_sum", 64'(bus.psum_out), 64'(2147483647));
    chk("ovf_flag", 64'(bus.ovf), 64'(1));
`else
    chk("ovf_sum", 64'(bus.psum_out), 64'(-2147483596));
    chk("ovf_flag", 64'(bus.ovf), 64'(0));
`endif
    drain();

    // Later beats keep adding to the clamped value; flag stays set
    start_win(2, 2147483600);
    beat(100);
    beat(-10);
`ifdef PSUM_SAT_EN
    chk("sticky_sum", 64'(bus.psum_out), 64'(2147483637));
    chk("sticky_flag", 64'(bus.ovf), 64'(1));
`else
    chk("sticky_sum", 64'(bus.psum_out), 64'(-2147483606));
    chk("sticky_flag", 64'(bus.ovf), 64'(0));
`endif
    drain();
    chk("ovf_cleared_idle_start", 64'(bus.busy), 64'(0));

    // Chained windows: new start accepted with psum_ready, start in ACCUM ignored
    start_win(2, 1);
    beat(2);
    beat(3);
    chk("chain_first", 64'(bus.psum_out), 64'(6));
    bus.psum_ready = 1'b1;
    start_win(2, 1000);
    bus.psum_ready = 1'b0;
    chk("chain_busy",  64'(bus.busy),       64'(1));
    chk("chain_accum", 64'(bus.prod_ready), 64'(1));
    chk("chain_ovf",   64'(bus.ovf),        64'(0));
    bus.start    = 1'b1;
    bus.filt_len = LEN_WIDTH'(7);
    bus.psum_in  = ACC_WIDTH'(5);
    beat(1);
    bus.start = 1'b0;
    beat(2);
    chk("chain_valid", 64'(bus.psum_valid), 64'(1));
    chk("chain_sum",   64'(bus.psum_out),   64'(1003));
    drain();

    // Longest window with the most negative product
    start_win(15, 0);
    for (int i = 0; i < 15; i++) beat(-8388608);
    chk("maxlen_valid", 64'(bus.psum_valid), 64'(1));
    chk("maxlen_sum",   64'(bus.psum_out),   64'(-125829120));
    drain();
    tick();

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
